// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table evaluator.
// The state enum is exported so checkers can watch the configuration FSM.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } tt_state_e;

   // Total table bits: one 2^n_in-deep column per output channel.
   function automatic int tt_width(input int n_in, input int n_out);
      return n_out * (1 << n_in);
   endfunction

   // Beat counter must reach tt_w itself during COMMIT, hence the extra bit.
   function automatic int cnt_width(input int tt_w);
      return $clog2(tt_w) + 1;
   endfunction

endpackage

// File: rtl/tt_lut_eval_if.sv
// Evaluation and configuration signals of tt_lut_eval, plus FSM state for debug.
// Handshake: a cfg beat transfers on a clock edge where cfg_valid && cfg_ready; in_valid is a plain strobe.
interface tt_lut_eval_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 1
);
   import tt_pkg::*;

   logic             in_valid;
   logic [N_IN-1:0]  in_data;
   logic             out_valid;
   logic [N_OUT-1:0] out_data;
   logic             cfg_valid;
   logic             cfg_data;
   logic             cfg_ready;
   logic             cfg_abort;
   logic             cfg_done;
   logic             cfg_busy;
   tt_state_e        cfg_state;

   modport master (
      output in_valid, in_data, cfg_valid, cfg_data, cfg_abort,
      input  out_valid, out_data, cfg_ready, cfg_done, cfg_busy, cfg_state
   );

   modport slave (
      input  in_valid, in_data, cfg_valid, cfg_data, cfg_abort,
      output out_valid, out_data, cfg_ready, cfg_done, cfg_busy, cfg_state
   );

endinterface

// File: rtl/tt_lut_mux.sv
// Selects one bit of a 2^N_IN-entry truth-table column by an N_IN-bit index.
module tt_lut_mux #(
   parameter int N_IN = 3
) (
   input  logic [(1<<N_IN)-1:0] tbl,
   input  logic [N_IN-1:0]      idx,
   output logic                 bit_out
);

   assign bit_out = tbl[idx];

endmodule

// File: rtl/tt_lut_eval.sv
// Programmable N_IN-input, N_OUT-channel truth-table evaluator with a serially
// loaded shadow table that is committed atomically while evaluation keeps running.
module tt_lut_eval
   import tt_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int N_OUT = 1,
   parameter logic [tt_width(N_IN, N_OUT)-1:0] DEFAULT_TT = 8'h97
) (
   input logic           clk,
   input logic           rst,
   tt_lut_eval_if.slave  bus
);

   localparam int DEPTH = 1 << N_IN;
   localparam int TT_W  = tt_width(N_IN, N_OUT);
   localparam int CW    = cnt_width(TT_W);

   tt_state_e        state, state_nxt;
   logic [TT_W-1:0]  active;
   logic [TT_W-1:0]  shadow;
   logic [CW-1:0]    count;
   logic [N_OUT-1:0] lut_bits;
   logic             out_valid_r;
   logic [N_OUT-1:0] out_data_r;
   logic             cfg_ready_c;
   logic             cfg_done_c;
   logic             cfg_busy_c;
   logic             abort_now;
   logic             accept;
   logic             last_beat;

   // Abort only matters outside COMMIT and wins over a same-cycle beat.
   assign abort_now = bus.cfg_abort && (state != COMMIT);
   assign accept    = bus.cfg_valid && cfg_ready_c && !abort_now;
   assign last_beat = (count == CW'(TT_W - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, LOAD: begin
            if (abort_now) begin
               state_nxt = IDLE;
            end else if (accept) begin
               state_nxt = last_beat ? COMMIT : LOAD;
            end
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      cfg_ready_c = 1'b1;
      cfg_done_c  = 1'b0;
      cfg_busy_c  = 1'b0;
      case (state)
         LOAD: begin
            cfg_busy_c = 1'b1;
         end
         COMMIT: begin
            cfg_ready_c = 1'b0;
            cfg_done_c  = 1'b1;
            cfg_busy_c  = 1'b1;
         end
         default: begin
            cfg_ready_c = 1'b1;
         end
      endcase
   end

   // Beat counter and shadow table; count is 0 in IDLE so the first beat lands in bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         shadow <= '0;
      end else begin
         if (state == COMMIT || abort_now) begin
            count <= '0;
         end else if (accept) begin
            count <= count + CW'(1);
         end
         for (int k = 0; k < TT_W; k++) begin
            if (accept && count == CW'(k)) begin
               shadow[k] <= bus.cfg_data;
            end
         end
      end
   end

   // Active table swaps at the end of COMMIT, so a same-cycle sample still sees the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= DEFAULT_TT;
      end else if (state == COMMIT) begin
         active <= shadow;
      end
   end

   for (genvar c = 0; c < N_OUT; c++) begin : g_ch
      tt_lut_mux #(.N_IN(N_IN)) u_mux (
         .tbl     (active[c*DEPTH +: DEPTH]),
         .idx     (bus.in_data),
         .bit_out (lut_bits[c])
      );
   end

   // Result register: out_data holds when no sample arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else begin
         out_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            out_data_r <= lut_bits;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.cfg_ready = cfg_ready_c;
   assign bus.cfg_done  = cfg_done_c;
   assign bus.cfg_busy  = cfg_busy_c;
   assign bus.cfg_state = state;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Directed bench for tt_lut_eval: default table, loads, commit boundary, abort,
// reset mid-load, and a 2-input 2-channel instance.
module tb_tt_lut_eval;
   import tt_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tt_lut_eval_if #(.N_IN(3), .N_OUT(1)) bus ();
   tt_lut_eval_if #(.N_IN(2), .N_OUT(2)) bus2 ();

   tt_lut_eval #(.N_IN(3), .N_OUT(1), .DEFAULT_TT(8'h97)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   tt_lut_eval #(.N_IN(2), .N_OUT(2), .DEFAULT_TT(8'hE4)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int tests = 0;
   int fails = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One clock; outputs are sampled 1 ns after the edge and scored against exp_q.
   task automatic tick();
      logic was_valid;
      was_valid = bus.in_valid && !rst;
      @(posedge clk);
      #1;
      if (was_valid) begin
         check("out_valid", 32'(bus.out_valid), 32'd1);
         if (exp_q.size() > 0) check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end else begin
         check("out_valid_idle", 32'(bus.out_valid), 32'd0);
      end
   endtask

   task automatic eval(input int d, input logic e);
      bus.in_valid = 1'b1;
      bus.in_data  = 3'(d);
      exp_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic sweep(input logic [7:0] tt);
      for (int i = 0; i < 8; i++) eval(i, tt[i]);
   endtask

   task automatic idle_checks();
      check("idle_state", 32'(bus.cfg_state), 32'(IDLE));
      check("idle_busy", 32'(bus.cfg_busy), 32'd0);
      check("idle_ready", 32'(bus.cfg_ready), 32'd1);
      check("idle_done", 32'(bus.cfg_done), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;  bus.in_data = '0;
      bus.cfg_valid = 1'b0; bus.cfg_data = 1'b0; bus.cfg_abort = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_data = '0;
      bus2.cfg_valid = 1'b0; bus2.cfg_data = 1'b0; bus2.cfg_abort = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      idle_checks();
   endtask

   task automatic load_beats(input logic [7:0] tt, input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            bus.cfg_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = tt[k];
         tick();
         if (k < 7) begin
            check("load_ready", 32'(bus.cfg_ready), 32'd1);
            check("load_busy", 32'(bus.cfg_busy), 32'd1);
            check("load_done", 32'(bus.cfg_done), 32'd0);
         end
      end
      bus.cfg_valid = 1'b0;
   endtask

   task automatic commit_checks();
      check("commit_done", 32'(bus.cfg_done), 32'd1);
      check("commit_ready", 32'(bus.cfg_ready), 32'd0);
      check("commit_busy", 32'(bus.cfg_busy), 32'd1);
      check("commit_state", 32'(bus.cfg_state), 32'(COMMIT));
   endtask

   logic [1:0] exp2 [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
   logic [7:0] tt2 = 8'b1000_0110;

   initial begin
      // Reset default table, back-to-back samples, then output hold
      do_reset();
      sweep(8'h97);
      tick();
      check("hold_data", 32'(bus.out_data), 32'd1);

      // AND3: gap-free load commits in cycle 9
      do_reset();
      load_beats(8'h80, 8, 1'b0);
      commit_checks();
      tick();
      idle_checks();
      sweep(8'h80);

      // Backpressured load of 8'h01; sample in COMMIT cycle sees old table
      do_reset();
      load_beats(8'h01, 8, 1'b1);
      commit_checks();
      eval(7, 1'b1);
      idle_checks();
      eval(7, 1'b0);
      eval(0, 1'b1);
      eval(1, 1'b0);

      // Abort with a same-cycle beat, then a clean reload
      do_reset();
      load_beats(8'h00, 4, 1'b0);
      bus.cfg_abort = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 1'b1;
      tick();
      bus.cfg_abort = 1'b0;
      bus.cfg_valid = 1'b0;
      idle_checks();
      eval(3, 1'b0);
      eval(0, 1'b1);
      load_beats(8'h80, 8, 1'b0);
      commit_checks();
      tick();
      eval(7, 1'b1);
      eval(6, 1'b0);
      eval(0, 1'b0);

      // Reset in the middle of a load
      do_reset();
      load_beats(8'hFF, 5, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_checks();
      eval(3, 1'b0);
      eval(7, 1'b1);
      load_beats(8'h0F, 8, 1'b0);
      commit_checks();
      tick();
      sweep(8'h0F);

      // Two-input, two-channel instance: ch0 XOR, ch1 AND
      for (int k = 0; k < 8; k++) begin
         bus2.cfg_valid = 1'b1;
         bus2.cfg_data  = tt2[k];
         tick();
      end
      bus2.cfg_valid = 1'b0;
      check("n2_done", 32'(bus2.cfg_done), 32'd1);
      tick();
      check("n2_idle", 32'(bus2.cfg_busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus2.in_valid = 1'b1;
         bus2.in_data  = 2'(i);
         tick();
         check("n2_out_valid", 32'(bus2.out_valid), 32'd1);
         check("n2_out_data", 32'(bus2.out_data), 32'(exp2[i]));
      end
      bus2.in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tt_lut_eval.md
Name: tt_lut_eval

Overview:
Programmable truth-table evaluator: the parametrised successor of the fixed 3-input case-statement logic gates used as synthesis targets. It evaluates N_IN-input, N_OUT-channel Boolean functions from an active truth table held in registers, with a registered output and a valid strobe. A new table can be streamed in serially and committed atomically without stalling evaluation. It sits between the netlist-synthesis test harness and circuit-model comparators as a reconfigurable golden model.

Parameters:
N_IN, 3, number of function inputs; table depth per channel is 2^N_IN.
N_OUT, 1, number of output channels, each with its own table.
DEFAULT_TT, 8'h97, table loaded at reset; width TT_W = N_OUT*2^N_IN. For the default, indices 0..7 map to 1,1,1,0,1,0,0,1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  evaluation sample strobe
in_data  in  N_IN  input vector; bit 0 is the LSB of the table index
out_valid  out  1  result strobe
out_data  out  N_OUT  result; bit c is channel c
cfg_valid  in  1  configuration beat valid
cfg_data  in  1  configuration bit
cfg_ready  out  1  configuration beat accepted when valid && ready
cfg_abort  in  1  discard the partial load
cfg_done  out  1  one-cycle commit pulse
cfg_busy  out  1  high while state is not IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No other clocks or resets.
- Reset values:
  - active table = DEFAULT_TT
  - shadow table = 0, beat count = 0, state = IDLE
  - out_valid = 0, out_data = 0, cfg_done = 0, cfg_busy = 0, cfg_ready = 1
- Table layout: table bit (c*2^N_IN + i) is the channel-c output for index i.
- Evaluation:
  - Latency 1. When in_valid is high at edge k, out_valid = 1 after edge k and out_data[c] = active[c*2^N_IN + in_data].
  - With no in_valid, out_valid = 0 and out_data holds its last value.
  - Full throughput: one sample per cycle, never stalled by configuration.
- Configuration FSM (IDLE, LOAD, COMMIT):
  - Configuration bits arrive LSB first: beat k writes shadow bit k.
  - IDLE: cfg_ready = 1. An accepted beat writes shadow[0], sets count = 1 and goes to LOAD. If TT_W == 1 it goes directly to COMMIT.
  - LOAD: cfg_ready = 1. Each accepted beat writes shadow[count] and increments count. Gaps in cfg_valid are allowed. Accepting beat TT_W-1 goes to COMMIT.
  - COMMIT, exactly one cycle:
    - cfg_ready = 0, cfg_done = 1.
    - active <= shadow at the end of the cycle, then go to IDLE with count = 0.
  - cfg_busy = 1 in LOAD and COMMIT.
- Simultaneous events:
  - An in_valid sample accepted during the COMMIT cycle uses the old table. Samples from the next cycle on use the new table.
  - cfg_abort in IDLE or LOAD takes priority over a same-cycle cfg_valid beat: the beat is dropped, state goes to IDLE, count = 0, active is unchanged.
  - cfg_abort during COMMIT is ignored; the commit completes.
- rst during LOAD or COMMIT: the partial or pending table is discarded and active returns to DEFAULT_TT.
- Count width is clog2(TT_W)+1. The count never exceeds TT_W-1 outside COMMIT.

Decomposition:
- Package tt_pkg holds:
  - the state enum (IDLE, LOAD, COMMIT)
  - function tt_width(n_in, n_out)
  - function cnt_width(tt_w)
- One combinational sub-module, tt_lut_mux: N_IN-bit index selecting one bit from a 2^N_IN table. It is instantiated N_OUT times.

Test Plan:
- Reset default: rst for 2 cycles, then in_data 0..7 with in_valid every cycle -> out_data 1,1,1,0,1,0,0,1, each one cycle after its input, and out_valid high for 8 cycles.
- AND3 load: stream 8 bits of 8'h80 with no gaps -> cfg_done in cycle 9, cfg_ready 0 that cycle; sweep 0..7 -> only index 7 gives 1.
- Backpressure and commit boundary: load 8'h01 with random cfg_valid gaps, and drive in_data=7 during the COMMIT cycle -> result 1 (old table 8'h97); in_data=7 the next cycle -> 0.
- Abort: 4 beats of 8'h00, then cfg_abort together with a cfg_valid beat -> state IDLE, cfg_busy 0, index 3 still gives 0 and index 0 still gives 1 (table 8'h97 intact).
- Reset mid-load: rst after 5 beats of 8'hFF -> cfg_busy 0 and outputs follow 8'h97; a subsequent full 8'h0F load commits correctly.
- N_IN=2, N_OUT=2: load 8'b1000_0110 (ch0 XOR, ch1 AND) -> in_data 0..3 gives out_data 00, 01, 01, 10.
